axi_req_arbiter: RTL and testbench
==================================

Name: axi_req_arbiter

Overview:
- Front-end scheduler for the AXI-to-APB bridge, on the AXI side of the top (request) asynchronous FIFO.
- Captures AXI write-address (AW), write-data (W) and read-address (AR) beats independently into holding registers.
- Joins AW with W, round-robin arbitrates between the write and read requests, and pushes one packed entry per cycle into the top FIFO.
- Limits in-flight transactions against response completions, replacing fixed write-over-read priority with fair, credit-limited sequencing.

Parameters:
- DATASIZE, 32, write data width; must be a multiple of 8.
- ADDRSIZE, 32, address width.
- MAX_OUTSTANDING, 4, maximum pushed but not yet completed transactions; legal range 1..15.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width; derived, not overridden.
- TOP_FIFO_DATA_SIZE, DATASIZE+ADDRSIZE+4+DATASIZE/8, packed entry width.

Ports:
- AXI_clk  in  1  single clock for all state.
- AXI_rst  in  1  asynchronous, active-high reset.
- aw_valid  in  1  write address valid.
- aw_addr  in  ADDRSIZE  write address.
- aw_prot  in  3  write protection.
- aw_ready  out  1  write address accepted.
- w_valid  in  1  write data valid.
- w_data  in  DATASIZE  write data.
- w_strb  in  DATASIZE/8  byte strobes.
- w_ready  out  1  write data accepted.
- ar_valid  in  1  read address valid.
- ar_addr  in  ADDRSIZE  read address.
- ar_prot  in  3  read protection.
- ar_ready  out  1  read address accepted.
- wfull_top  in  1  top FIFO full.
- winc_top  out  1  top FIFO push strobe.
- conc_data  out  TOP_FIFO_DATA_SIZE  packed entry.
- rsp_done  in  1  one transaction completed (B or R beat handed to the master).
- outstanding  out  CNT_W  current in-flight count.
- credit_err  out  1  sticky: rsp_done arrived while outstanding==0.

Behaviour:
- Reset (async assert, synchronous release):
  - aw_hold_v, w_hold_v, ar_hold_v = 0.
  - outstanding = 0; credit_err = 0; rr_state = PRIO_WR.
  - All hold data registers = 0.
  - Outputs during reset: aw_ready/w_ready/ar_ready = 1 (holds empty), winc_top = 0, conc_data = 0.
- Holding registers (one entry each):
  - aw_ready = !aw_hold_v | push_wr; w_ready = !w_hold_v | push_wr; ar_ready = !ar_hold_v | push_rd.
  - A beat is captured on valid&ready at the clock edge.
  - AW and W are captured independently, in any order, or in the same cycle.
- Request eligibility:
  - wr_req = aw_hold_v & w_hold_v.
  - rd_req = ar_hold_v.
  - can_push = !wfull_top & (outstanding < MAX_OUTSTANDING).
- Arbiter FSM, states PRIO_WR and PRIO_RD:
  - Only wr_req and can_push: push_wr.
  - Only rd_req and can_push: push_rd.
  - Both and can_push: grant the state's priority side, then move to the other state.
  - A single-requester grant sets state to the opposite of the granted side.
  - No push: state holds.
- Push is combinational from registered holds:
  - winc_top = push_wr | push_rd; at most one per cycle.
  - Latency: beat accepted at edge N, winc_top high in cycle N+1 at the earliest.
- Entry format, MSB to LSB: {data, strb, prot, addr, write_read}.
  - Write entry: w_data, w_strb, aw_prot, aw_addr, 1.
  - Read entry: data 0, strb 0, ar_prot, ar_addr, 0.
  - No push: conc_data = 0.
- Hold clearing and refill:
  - The pushed side's hold registers clear at the push edge, unless refilled in the same cycle.
  - Same-cycle pop and refill sustains one beat per cycle per channel.
- Outstanding counter:
  - +1 on push; -1 on rsp_done; unchanged when both occur in the same cycle.
  - rsp_done with outstanding==0: counter stays 0 and credit_err sets; credit_err clears only on reset.
- Full FIFO or credit stall: holds keep their contents; ready deasserts once the holds are full; no beat is lost or duplicated.
- Reset mid-operation: held beats are discarded; the AXI master must restart the transaction.

Decomposition:
- Shared package bridge_pkg:
  - Entry field offsets: WR_BIT = 0; ADDR_LSB = 1; PROT_LSB = ADDRSIZE+1; STRB_LSB = ADDRSIZE+4; DATA_LSB = ADDRSIZE+4+DATASIZE/8.
  - Enum rr_state_t {PRIO_WR, PRIO_RD}.
- One sub-module, req_hold_reg: a parameterised one-entry valid/data holding register with load and clear. It is instantiated three times (AW, W, AR).

Test Plan:
- Single write: AW addr=0x1000, prot=0, and W data=0xDEADBEEF, strb=0xF in the same cycle -> one winc_top next cycle; conc_data = {0xDEADBEEF, 4'hF, 3'b000, 0x1000, 1'b1}; outstanding = 1.
- W arrives 3 cycles before AW (addr 0x2004) -> no push until AW is held; then exactly one push carrying 0x2004.
- Write and read held simultaneously from reset -> write pushed first, read next cycle. Repeat with continuous requests -> strict alternation W, R, W, R.
- MAX_OUTSTANDING=4:
  - Push 4 reads, no rsp_done -> 5th read is held, winc_top stays 0, ar_ready = 0.
  - One rsp_done -> 5th pushed the next cycle; outstanding returns to 4.
- wfull_top=1 for 5 cycles with write pending -> no push, hold data stable. Deassert -> single push with the original data.
- rsp_done at outstanding=0 -> credit_err = 1, outstanding = 0.
- AXI_rst pulse mid-hold -> all holds cleared, outstanding = 0, credit_err = 0, no push after release.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AXI-to-APB bridge: request entry field layout
// and the round-robin arbiter state type.
package bridge_pkg;

    localparam int WR_BIT   = 0;
    localparam int ADDR_LSB = 1;

    function automatic int prot_lsb(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic int strb_lsb(input int addrsize);
        return addrsize + 4;
    endfunction

    function automatic int data_lsb(input int addrsize, input int datasize);
        return addrsize + 4 + datasize / 8;
    endfunction

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } rr_state_t;

endpackage

// File: rtl/axi_req_arbiter_if.sv
// AXI request channels, top-FIFO push side and credit signals of the
// request arbiter, bundled with master (AXI side) and slave (arbiter) views.
interface axi_req_arbiter_if #(
    parameter int DATASIZE        = 32,
    parameter int ADDRSIZE        = 32,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CNT_W              = $clog2(MAX_OUTSTANDING + 1);
    localparam int TOP_FIFO_DATA_SIZE = DATASIZE + ADDRSIZE + 4 + DATASIZE / 8;

    logic                          aw_valid;
    logic [ADDRSIZE-1:0]           aw_addr;
    logic [2:0]                    aw_prot;
    logic                          aw_ready;
    logic                          w_valid;
    logic [DATASIZE-1:0]           w_data;
    logic [DATASIZE/8-1:0]         w_strb;
    logic                          w_ready;
    logic                          ar_valid;
    logic [ADDRSIZE-1:0]           ar_addr;
    logic [2:0]                    ar_prot;
    logic                          ar_ready;
    logic                          wfull_top;
    logic                          winc_top;
    logic [TOP_FIFO_DATA_SIZE-1:0] conc_data;
    logic                          rsp_done;
    logic [CNT_W-1:0]              outstanding;
    logic                          credit_err;

    modport slave (
        input  aw_valid, aw_addr, aw_prot,
        output aw_ready,
        input  w_valid, w_data, w_strb,
        output w_ready,
        input  ar_valid, ar_addr, ar_prot,
        output ar_ready,
        input  wfull_top,
        output winc_top, conc_data,
        input  rsp_done,
        output outstanding, credit_err
    );

    modport master (
        output aw_valid, aw_addr, aw_prot,
        input  aw_ready,
        output w_valid, w_data, w_strb,
        input  w_ready,
        output ar_valid, ar_addr, ar_prot,
        input  ar_ready,
        output wfull_top,
        input  winc_top, conc_data,
        output rsp_done,
        input  outstanding, credit_err
    );

endinterface

// File: rtl/req_hold_reg.sv
// One-entry valid/data holding register. A load wins over a clear so a
// popped entry can be refilled in the same cycle.
module req_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end
    end

endmodule

// File: rtl/axi_req_arbiter.sv
// AXI request front end: holds AW/W/AR beats, joins AW with W, round-robins
// writes against reads and pushes one packed entry per cycle, credit-limited.
module axi_req_arbiter
    import bridge_pkg::*;
#(
    parameter int  DATASIZE           = 32,
    parameter int  ADDRSIZE           = 32,
    parameter int  MAX_OUTSTANDING    = 4,
    localparam int CNT_W              = $clog2(MAX_OUTSTANDING + 1),
    localparam int TOP_FIFO_DATA_SIZE = DATASIZE + ADDRSIZE + 4 + DATASIZE / 8
) (
    input  logic             AXI_clk,
    input  logic             AXI_rst,
    axi_req_arbiter_if.slave bus
);

    localparam int STRB_W = DATASIZE / 8;
    localparam int A_W    = ADDRSIZE + 3;
    localparam int W_W    = DATASIZE + STRB_W;
    localparam int P_LSB  = prot_lsb(ADDRSIZE);
    localparam int S_LSB  = strb_lsb(ADDRSIZE);
    localparam int D_LSB  = data_lsb(ADDRSIZE, DATASIZE);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic                          aw_hold_v;
    logic                          w_hold_v;
    logic                          ar_hold_v;
    logic [A_W-1:0]                aw_hold_q;
    logic [W_W-1:0]                w_hold_q;
    logic [A_W-1:0]                ar_hold_q;
    logic                          aw_ready;
    logic                          w_ready;
    logic                          ar_ready;
    logic                          wr_req;
    logic                          rd_req;
    logic                          can_push;
    logic                          push_wr;
    logic                          push_rd;
    logic                          winc;
    logic [TOP_FIFO_DATA_SIZE-1:0] conc;
    logic [CNT_W-1:0]              out_cnt;
    logic                          credit_err_q;
    rr_state_t                     rr_state;
    rr_state_t                     rr_next;

    // A full hold still accepts a beat in the cycle its contents are pushed.
    assign aw_ready = !aw_hold_v | push_wr;
    assign w_ready  = !w_hold_v  | push_wr;
    assign ar_ready = !ar_hold_v | push_rd;

    req_hold_reg #(.WIDTH(A_W)) u_aw_hold (
        .clk   (AXI_clk),
        .rst   (AXI_rst),
        .load  (bus.aw_valid & aw_ready),
        .clear (push_wr),
        .d     ({bus.aw_prot, bus.aw_addr}),
        .valid (aw_hold_v),
        .q     (aw_hold_q)
    );

    req_hold_reg #(.WIDTH(W_W)) u_w_hold (
        .clk   (AXI_clk),
        .rst   (AXI_rst),
        .load  (bus.w_valid & w_ready),
        .clear (push_wr),
        .d     ({bus.w_data, bus.w_strb}),
        .valid (w_hold_v),
        .q     (w_hold_q)
    );

    req_hold_reg #(.WIDTH(A_W)) u_ar_hold (
        .clk   (AXI_clk),
        .rst   (AXI_rst),
        .load  (bus.ar_valid & ar_ready),
        .clear (push_rd),
        .d     ({bus.ar_prot, bus.ar_addr}),
        .valid (ar_hold_v),
        .q     (ar_hold_q)
    );

    assign wr_req   = aw_hold_v & w_hold_v;
    assign rd_req   = ar_hold_v;
    assign can_push = !bus.wfull_top & (out_cnt < MAX_CNT);

    always_ff @(posedge AXI_clk or posedge AXI_rst) begin
        if (AXI_rst) begin
            rr_state <= PRIO_WR;
        end else begin
            rr_state <= rr_next;
        end
    end

    // Whichever side is granted, priority moves to the other side.
    always_comb begin
        push_wr = 1'b0;
        push_rd = 1'b0;
        rr_next = rr_state;
        if (can_push) begin
            if (wr_req && (!rd_req || rr_state == PRIO_WR)) begin
                push_wr = 1'b1;
                rr_next = PRIO_RD;
            end else if (rd_req) begin
                push_rd = 1'b1;
                rr_next = PRIO_WR;
            end
        end
    end

    assign winc = push_wr | push_rd;

    always_comb begin
        conc = '0;
        if (push_wr) begin
            conc[WR_BIT]              = 1'b1;
            conc[ADDR_LSB +: ADDRSIZE] = aw_hold_q[ADDRSIZE-1:0];
            conc[P_LSB +: 3]          = aw_hold_q[ADDRSIZE +: 3];
            conc[S_LSB +: STRB_W]     = w_hold_q[STRB_W-1:0];
            conc[D_LSB +: DATASIZE]   = w_hold_q[STRB_W +: DATASIZE];
        end else if (push_rd) begin
            conc[ADDR_LSB +: ADDRSIZE] = ar_hold_q[ADDRSIZE-1:0];
            conc[P_LSB +: 3]          = ar_hold_q[ADDRSIZE +: 3];
        end
    end

    // A completion with nothing in flight is a protocol error, never an underflow.
    always_ff @(posedge AXI_clk or posedge AXI_rst) begin
        if (AXI_rst) begin
            out_cnt      <= '0;
            credit_err_q <= 1'b0;
        end else begin
            if (bus.rsp_done && out_cnt == '0) begin
                credit_err_q <= 1'b1;
            end
            if (winc && !bus.rsp_done) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end else if (!winc && bus.rsp_done && out_cnt != '0) begin
                out_cnt <= out_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.aw_ready    = aw_ready;
    assign bus.w_ready     = w_ready;
    assign bus.ar_ready    = ar_ready;
    assign bus.winc_top    = winc;
    assign bus.conc_data   = conc;
    assign bus.outstanding = out_cnt;
    assign bus.credit_err  = credit_err_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench for axi_req_arbiter: accepted beats are queued per channel,
// a monitor derives each cycle's expected push from the queues and compares.
module tb_axi_req_arbiter;

    localparam int DATASIZE = 32;
    localparam int ADDRSIZE = 32;
    localparam int MAX_OUT  = 4;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  prot;
    } a_beat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_req_arbiter_if #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE), .MAX_OUTSTANDING(MAX_OUT)) bus ();

    axi_req_arbiter #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .AXI_clk (clk),
        .AXI_rst (rst),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    a_beat_t aw_q[$];
    w_beat_t w_q[$];
    a_beat_t ar_q[$];
    int      out_model = 0;
    bit      err_model = 0;
    bit      last_wr   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accepted beats enter the model just before the capturing edge.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (bus.aw_valid && bus.aw_ready) aw_q.push_back('{addr: bus.aw_addr, prot: bus.aw_prot});
            if (bus.w_valid && bus.w_ready) w_q.push_back('{data: bus.w_data, strb: bus.w_strb});
            if (bus.ar_valid && bus.ar_ready) ar_q.push_back('{addr: bus.ar_addr, prot: bus.ar_prot});
        end
    end

    always begin
        logic [71:0] exp_entry;
        bit pw, pr, can, gw, gr;
        @(negedge clk);
        if (rst) begin
            aw_q.delete();
            w_q.delete();
            ar_q.delete();
            out_model = 0;
            err_model = 0;
            last_wr   = 0;
            check("rst_aw_ready", bus.aw_ready, 1);
            check("rst_w_ready", bus.w_ready, 1);
            check("rst_ar_ready", bus.ar_ready, 1);
            check("rst_winc", bus.winc_top, 0);
            check("rst_conc", bus.conc_data, 0);
            check("rst_outstanding", bus.outstanding, 0);
            check("rst_credit_err", bus.credit_err, 0);
        end else begin
            pw  = (aw_q.size() > 0) && (w_q.size() > 0);
            pr  = ar_q.size() > 0;
            can = !bus.wfull_top && (out_model < MAX_OUT);
            gw  = can && pw && (!pr || !last_wr);
            gr  = can && pr && !gw;
            exp_entry = '0;
            if (gw) exp_entry = {w_q[0].data, w_q[0].strb, aw_q[0].prot, aw_q[0].addr, 1'b1};
            if (gr) exp_entry = {32'h0, 4'h0, ar_q[0].prot, ar_q[0].addr, 1'b0};
            check("mon_winc", bus.winc_top, gw | gr);
            check("mon_conc", bus.conc_data, exp_entry);
            check("mon_aw_ready", bus.aw_ready, (aw_q.size() == 0) || gw);
            check("mon_w_ready", bus.w_ready, (w_q.size() == 0) || gw);
            check("mon_ar_ready", bus.ar_ready, (ar_q.size() == 0) || gr);
            check("mon_outstanding", bus.outstanding, out_model);
            check("mon_credit_err", bus.credit_err, err_model);
            if (gw) begin
                void'(aw_q.pop_front());
                void'(w_q.pop_front());
                last_wr = 1;
            end
            if (gr) begin
                void'(ar_q.pop_front());
                last_wr = 0;
            end
            if (bus.rsp_done && out_model == 0) err_model = 1;
            if ((gw || gr) && !bus.rsp_done) out_model++;
            else if (!(gw || gr) && bus.rsp_done && out_model > 0) out_model--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
        bit ok;
        ok = 0;
        bus.ar_valid = 1'b1;
        bus.ar_addr  = a;
        bus.ar_prot  = p;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = bus.ar_ready;
            tick();
        end
        bus.ar_valid = 1'b0;
        check("send_ar_accept", ok, 1);
    endtask

    task automatic drain(input int n);
        bus.rsp_done = 1'b1;
        repeat (n) tick();
        bus.rsp_done = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic [2:0]  rp;
        logic [3:0]  rs;
        bit aw_acc, w_acc, ar_acc;

        rst = 1'b1;
        bus.aw_valid = 0; bus.aw_addr = 0; bus.aw_prot = 0;
        bus.w_valid = 0;  bus.w_data = 0;  bus.w_strb = 0;
        bus.ar_valid = 0; bus.ar_addr = 0; bus.ar_prot = 0;
        bus.wfull_top = 0; bus.rsp_done = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single write with AW and W together
        bus.aw_valid = 1; bus.aw_addr = 32'h1000; bus.aw_prot = 3'b000;
        bus.w_valid = 1;  bus.w_data = 32'hDEADBEEF; bus.w_strb = 4'hF;
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        check("t1_winc", bus.winc_top, 1);
        check("t1_entry", bus.conc_data, {32'hDEADBEEF, 4'hF, 3'b000, 32'h1000, 1'b1});
        tick();
        check("t1_outstanding", bus.outstanding, 1);
        check("t1_single_push", bus.winc_top, 0);

        // W leads AW by three cycles
        bus.w_valid = 1; bus.w_data = 32'hCAFE0123; bus.w_strb = 4'h3;
        tick();
        bus.w_valid = 0;
        repeat (3) begin
            check("t2_no_push", bus.winc_top, 0);
            tick();
        end
        bus.aw_valid = 1; bus.aw_addr = 32'h2004; bus.aw_prot = 3'b010;
        tick();
        bus.aw_valid = 0;
        check("t2_winc", bus.winc_top, 1);
        check("t2_entry", bus.conc_data, {32'hCAFE0123, 4'h3, 3'b010, 32'h2004, 1'b1});
        tick();
        check("t2_single_push", bus.winc_top, 0);
        check("t2_outstanding", bus.outstanding, 2);
        drain(2);
        check("t2_drained", bus.outstanding, 0);

        // Write and read pending together from reset, then continuous alternation
        do_reset();
        bus.aw_valid = 1; bus.aw_addr = 32'h3000; bus.aw_prot = 3'b001;
        bus.w_valid = 1;  bus.w_data = 32'h11112222; bus.w_strb = 4'hF;
        bus.ar_valid = 1; bus.ar_addr = 32'h4000; bus.ar_prot = 3'b010;
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.rsp_done = (i > 0);
            check("t3_winc", bus.winc_top, 1);
            check("t3_side", bus.conc_data[0], (i % 2 == 0));
            tick();
        end
        bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0; bus.rsp_done = 0;
        do_reset();

        // Credit limit: five reads, only four may be in flight
        for (int i = 0; i < 5; i++) send_ar(32'h100 + 32'(i * 4), 3'(i));
        repeat (2) begin
            check("t4_stall_winc", bus.winc_top, 0);
            check("t4_stall_ar_ready", bus.ar_ready, 0);
            check("t4_stall_outstanding", bus.outstanding, 4);
            tick();
        end
        bus.rsp_done = 1;
        tick();
        bus.rsp_done = 0;
        check("t4_release_winc", bus.winc_top, 1);
        check("t4_release_entry", bus.conc_data, {32'h0, 4'h0, 3'd4, 32'h110, 1'b0});
        tick();
        check("t4_outstanding_back", bus.outstanding, 4);
        check("t4_single_push", bus.winc_top, 0);
        drain(4);
        check("t4_drained", bus.outstanding, 0);

        // Full top FIFO with a write pending
        ra = $urandom; rd = $urandom; rp = 3'($urandom); rs = 4'($urandom);
        bus.wfull_top = 1;
        bus.aw_valid = 1; bus.aw_addr = ra; bus.aw_prot = rp;
        bus.w_valid = 1;  bus.w_data = rd;  bus.w_strb = rs;
        tick();
        bus.aw_valid = 0; bus.w_valid = 0;
        repeat (5) begin
            check("t5_full_winc", bus.winc_top, 0);
            check("t5_full_aw_ready", bus.aw_ready, 0);
            check("t5_full_w_ready", bus.w_ready, 0);
            tick();
        end
        bus.wfull_top = 0;
        #1;
        check("t5_winc", bus.winc_top, 1);
        check("t5_entry", bus.conc_data, {rd, rs, rp, ra, 1'b1});
        tick();
        check("t5_single_push", bus.winc_top, 0);
        drain(1);

        // Completion with nothing in flight
        check("t6_pre_outstanding", bus.outstanding, 0);
        bus.rsp_done = 1;
        tick();
        bus.rsp_done = 0;
        check("t6_credit_err", bus.credit_err, 1);
        check("t6_outstanding", bus.outstanding, 0);
        tick();
        check("t6_credit_err_sticky", bus.credit_err, 1);

        // Reset while beats are held
        send_ar(32'h500, 3'b000);
        tick();
        bus.wfull_top = 1;
        bus.aw_valid = 1; bus.aw_addr = 32'h600; bus.aw_prot = 3'b011;
        tick();
        bus.aw_valid = 0;
        send_ar(32'h700, 3'b001);
        rst = 1;
        #1;
        check("t7_aw_ready", bus.aw_ready, 1);
        check("t7_w_ready", bus.w_ready, 1);
        check("t7_ar_ready", bus.ar_ready, 1);
        check("t7_winc", bus.winc_top, 0);
        check("t7_conc", bus.conc_data, 0);
        check("t7_outstanding", bus.outstanding, 0);
        check("t7_credit_err", bus.credit_err, 0);
        tick();
        rst = 0;
        bus.wfull_top = 0;
        repeat (2) begin
            check("t7_no_push_after", bus.winc_top, 0);
            tick();
        end
        bus.w_valid = 1; bus.w_data = 32'h0BADF00D; bus.w_strb = 4'h5;
        tick();
        bus.w_valid = 0;
        repeat (3) begin
            check("t7_aw_discarded", bus.winc_top, 0);
            tick();
        end
        bus.aw_valid = 1; bus.aw_addr = 32'h800; bus.aw_prot = 3'b100;
        tick();
        bus.aw_valid = 0;
        check("t7_entry", bus.conc_data, {32'h0BADF00D, 4'h5, 3'b100, 32'h800, 1'b1});
        tick();
        drain(1);

        // Randomised traffic with back-pressure and completions
        aw_acc = 0; w_acc = 0; ar_acc = 0;
        repeat (1500) begin
            if (!bus.aw_valid || aw_acc) begin
                bus.aw_valid = 1'($urandom_range(0, 1));
                bus.aw_addr  = $urandom;
                bus.aw_prot  = 3'($urandom);
            end
            if (!bus.w_valid || w_acc) begin
                bus.w_valid = 1'($urandom_range(0, 1));
                bus.w_data  = $urandom;
                bus.w_strb  = 4'($urandom);
            end
            if (!bus.ar_valid || ar_acc) begin
                bus.ar_valid = 1'($urandom_range(0, 1));
                bus.ar_addr  = $urandom;
                bus.ar_prot  = 3'($urandom);
            end
            bus.wfull_top = ($urandom_range(0, 3) == 0);
            bus.rsp_done  = (out_model > 0) && ($urandom_range(0, 2) == 0);
            #7;
            aw_acc = bus.aw_valid && bus.aw_ready;
            w_acc  = bus.w_valid && bus.w_ready;
            ar_acc = bus.ar_valid && bus.ar_ready;
            tick();
        end
        bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0;
        bus.wfull_top = 0; bus.rsp_done = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
